// File: rtl/sdram_port_responder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sdram_port_responder_if
//  Description : Byte-wide SDRAM controller user port bundle (requests from
//                the memory-test master, read data and status back).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_port_responder_if;
  logic [22:0] addr;
  logic        rd;
  logic        wr;
  logic        refresh;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        data_ready;
  logic        busy;

  modport master (
    output addr, rd, wr, refresh, din,
    input  dout, data_ready, busy
  );

  modport slave (
    input  addr, rd, wr, refresh, din,
    output dout, data_ready, busy
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sdram_port_responder
//  Description : BRAM-backed stand-in for the byte-wide SDRAM controller.
//                Emulates init/read/write/refresh busy timing, flags illegal
//                commands and late refreshes for on-chip diagnostics.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_responder #(
  parameter int FREQ        = 27_000_000,
  parameter int MEM_AW      = 14,
  parameter int INIT_CYCLES = 16,
  parameter int RD_LAT      = 4,
  parameter int WR_LAT      = 3,
  parameter int REF_LAT     = 6,
  parameter int REF_MAX_US  = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  sdram_port_responder_if.slave port,
  output logic                  cmd_err,
  output logic [7:0]            err_count,
  output logic                  refresh_late,
  output logic [15:0]           refresh_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEPTH    = 1 << MEM_AW;
  localparam int WD_LIMIT = FREQ / 1_000_000 * REF_MAX_US;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam int CNT_MAX  = max2(max2(INIT_CYCLES, RD_LAT), max2(WR_LAT, REF_LAT));
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  // Elaboration-time sanity on the latency parameters.
  if (INIT_CYCLES < 1) begin : g_bad_init
    $error("INIT_CYCLES must be at least 1");
  end
  if (RD_LAT < 2) begin : g_bad_rd_lat
    $error("RD_LAT must be at least 2");
  end
  if (WR_LAT < 1) begin : g_bad_wr_lat
    $error("WR_LAT must be at least 1");
  end
  if (REF_LAT < 1) begin : g_bad_ref_lat
    $error("REF_LAT must be at least 1");
  end
  if (WD_LIMIT < 1) begin : g_bad_wd
    $error("refresh watchdog limit must be at least 1 cycle");
  end

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_REFRESH = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              busy_flag;
  logic              ready_pulse;
  logic [7:0]        dout_data;
  logic [7:0]        rd_word;
  logic [7:0]        mem [DEPTH];

  logic              req_any;
  logic              req_multi;
  logic              accept;
  logic              illegal;
  logic              rd_accept;
  logic              wr_accept;
  logic              ref_accept;
  logic [MEM_AW-1:0] mem_idx;

  // Upper address bits alias onto the same bytes and are deliberately ignored.
  if (MEM_AW < 23) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^port.addr[22:MEM_AW];
  end

  assign req_any   = port.rd | port.wr | port.refresh;
  assign req_multi = (port.rd & port.wr) | (port.rd & port.refresh) | (port.wr & port.refresh);
  assign accept    = ~reset & ~busy_flag & req_any & ~req_multi;
  assign illegal   = ~reset & req_any & (busy_flag | req_multi);
  assign rd_accept = accept & port.rd;
  assign wr_accept = accept & port.wr;
  assign ref_accept = accept & port.refresh;
  assign mem_idx   = port.addr[MEM_AW-1:0];

  assign port.busy       = busy_flag;
  assign port.data_ready = ready_pulse;
  assign port.dout       = dout_data;

  // Single-port BRAM: write at accept, capture the addressed byte on read accept.
  // Contents survive reset on purpose so a post-reset read sees old data.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[mem_idx] <= port.din;
    end
    if (rd_accept) begin
      rd_word <= mem[mem_idx];
    end
  end

  // Command sequencer: init delay, then per-command busy windows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_INIT;
      cnt           <= CNT_W'(INIT_CYCLES - 1);
      busy_flag     <= 1'b1;
      ready_pulse   <= 1'b0;
      dout_data     <= 8'h00;
      refresh_count <= 16'h0000;
    end else begin
      ready_pulse <= 1'b0;
      case (state)
        S_INIT: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            busy_flag <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            busy_flag <= 1'b1;
            if (port.rd) begin
              state <= S_READ;
              cnt   <= CNT_W'(RD_LAT - 1);
            end else if (port.wr) begin
              state <= S_WRITE;
              cnt   <= CNT_W'(WR_LAT - 1);
            end else begin
              state         <= S_REFRESH;
              cnt           <= CNT_W'(REF_LAT - 1);
              refresh_count <= refresh_count + 16'd1;
            end
          end
        end
        S_READ: begin
          // Data is presented one cycle before the busy window closes.
          if (cnt == CNT_W'(1)) begin
            dout_data   <= rd_word;
            ready_pulse <= 1'b1;
          end
          if (cnt == '0) begin
            state     <= S_IDLE;
            busy_flag <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WRITE, S_REFRESH: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            busy_flag <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy_flag <= 1'b0;
        end
      endcase
    end
  end

  // Illegal-command tracking: one count per offending cycle, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_err   <= 1'b0;
      err_count <= 8'h00;
    end else if (illegal) begin
      cmd_err <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // Refresh watchdog: runs outside INIT, cleared by refresh accept, saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt       <= '0;
      refresh_late <= 1'b0;
    end else if (state != S_INIT) begin
      if (ref_accept) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_W'(WD_LIMIT)) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_W'(WD_LIMIT - 1)) begin
          refresh_late <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
